// File: rtl/signed_seq_divider_if.sv
// Handshake bundle for the sequential signed divider.
// The producer/consumer side uses master and the divider uses slave.
interface signed_seq_divider_if #(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           ovf;
  logic           dbz;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, ovf, dbz
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, ovf, dbz
  );
endinterface

// File: rtl/signed_seq_divider.sv
// Radix-2 restoring signed divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder.
// Magnitudes are divided MSB first, then signs, saturation and divide-by-zero are applied in one fix-up cycle.
module signed_seq_divider #(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  signed_seq_divider_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CW = $clog2(2*W);
  localparam logic [2*W-1:0] Q_POS_LIM = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [2*W-1:0] Q_NEG_LIM = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]   SAT_POS   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]   SAT_NEG   = {1'b1, {(W-1){1'b0}}};

  function automatic logic [2*W-1:0] abs_wide(input logic [2*W-1:0] v);
    return v[2*W-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [W-1:0] abs_narrow(input logic [W-1:0] v);
    return v[W-1] ? (~v + 1'b1) : v;
  endfunction

  state_t         state_r;
  logic [2*W-1:0] dvd_r;      // dividend magnitude shifting out, quotient bits shifting in
  logic [W-1:0]   dvs_r;
  logic [W-1:0]   rem_r;
  logic [CW-1:0]  cnt_r;
  logic           sd_r;
  logic           sv_r;
  logic           dbz_pend_r;
  logic           in_ready_r;
  logic           out_valid_r;
  logic [W-1:0]   quo_r;
  logic [W-1:0]   rem_out_r;
  logic           ovf_r;
  logic           dbz_r;

  logic [W:0]     shift_s;
  logic           borrow_s;
  logic [W-1:0]   rem_next_s;
  logic           pos_s;
  logic           over_s;
  logic [W-1:0]   fix_q_s;
  logic [W-1:0]   fix_r_s;
  logic           fix_ovf_s;

  // One restoring step: shift in the next dividend bit and trial-subtract the divisor.
  always_comb begin
    shift_s    = {rem_r, dvd_r[2*W-1]};
    borrow_s   = (shift_s < {1'b0, dvs_r});
    rem_next_s = borrow_s ? shift_s[W-1:0] : W'(shift_s - {1'b0, dvs_r});
  end

  // Sign application, saturation and divide-by-zero substitution on the finished magnitudes.
  always_comb begin
    pos_s     = ~(sd_r ^ sv_r);
    over_s    = pos_s ? (dvd_r > Q_POS_LIM) : (dvd_r > Q_NEG_LIM);
    fix_q_s   = pos_s ? dvd_r[W-1:0] : (~dvd_r[W-1:0] + 1'b1);
    fix_r_s   = sd_r ? (~rem_r + 1'b1) : rem_r;
    fix_ovf_s = 1'b0;
    if (dbz_pend_r) begin
      fix_q_s   = sd_r ? SAT_NEG : SAT_POS;
      fix_r_s   = {W{1'b0}};
      fix_ovf_s = 1'b0;
    end else if (over_s) begin
      fix_q_s   = pos_s ? SAT_POS : SAT_NEG;
      fix_r_s   = {W{1'b0}};
      fix_ovf_s = 1'b1;
    end else begin
      fix_ovf_s = 1'b0;
    end
  end

  // Control FSM with datapath registers and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      dvd_r       <= {(2*W){1'b0}};
      dvs_r       <= {W{1'b0}};
      rem_r       <= {W{1'b0}};
      cnt_r       <= {CW{1'b0}};
      sd_r        <= 1'b0;
      sv_r        <= 1'b0;
      dbz_pend_r  <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      quo_r       <= {W{1'b0}};
      rem_out_r   <= {W{1'b0}};
      ovf_r       <= 1'b0;
      dbz_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            dvd_r      <= abs_wide(bus.dividend);
            dvs_r      <= abs_narrow(bus.divisor);
            sd_r       <= bus.dividend[2*W-1];
            sv_r       <= bus.divisor[W-1];
            dbz_pend_r <= (bus.divisor == {W{1'b0}});
            rem_r      <= {W{1'b0}};
            cnt_r      <= CW'(2*W-1);
            in_ready_r <= 1'b0;
            state_r    <= CALC;
          end
        end
        CALC: begin
          rem_r <= rem_next_s;
          dvd_r <= {dvd_r[2*W-2:0], ~borrow_s};
          if (cnt_r == {CW{1'b0}}) begin
            state_r <= FIX;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        FIX: begin
          quo_r       <= fix_q_s;
          rem_out_r   <= fix_r_s;
          ovf_r       <= fix_ovf_s;
          dbz_r       <= dbz_pend_r;
          out_valid_r <= 1'b1;
          state_r     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.quotient  = quo_r;
  assign bus.remainder = rem_out_r;
  assign bus.ovf       = ovf_r;
  assign bus.dbz       = dbz_r;

endmodule

// File: tb/tb_signed_seq_divider.sv
// Self-checking bench for signed_seq_divider (W=8): directed spec vectors, handshake/reset
// scenarios and randomized operands against an integer-arithmetic reference model.
module tb_signed_seq_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  signed_seq_divider_if #(.W(8)) bus();
  signed_seq_divider #(.W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] dir_a  [7] = '{16'd100, 16'hFF9C, 16'd100, 16'hC080, 16'h8000, 16'd5, 16'hFFFB};
  logic [7:0]  dir_b  [7] = '{8'd7, 8'd7, 8'hF9, 8'h80, 8'hFF, 8'h00, 8'h00};
  logic [7:0]  dir_q  [7] = '{8'h0E, 8'hF2, 8'hF2, 8'h7F, 8'h7F, 8'h7F, 8'h80};
  logic [7:0]  dir_r  [7] = '{8'h02, 8'hFE, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
  logic        dir_o  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        dir_z  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  // Reference: truncating integer division with saturation rules.
  function automatic void ref_div(input logic [15:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic o, output logic z);
    int ai, bi, qt, rt;
    ai = $signed(a);
    bi = $signed(b);
    o = 1'b0; z = 1'b0;
    if (bi == 0) begin
      z = 1'b1;
      q = (ai >= 0) ? 8'h7F : 8'h80;
      r = 8'h00;
    end else begin
      qt = ai / bi;
      rt = ai % bi;
      if (qt > 127 || qt < -128) begin
        o = 1'b1;
        q = (qt > 0) ? 8'h7F : 8'h80;
        r = 8'h00;
      end else begin
        q = qt[7:0];
        r = rt[7:0];
      end
    end
  endfunction

  // Runs one operation from a negedge; returns outputs and the cycle index where out_valid rose.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic o, output logic z, output int lat, output bit ok);
    int guard;
    ok = 1'b1; lat = 0; guard = 0;
    q = 8'h00; r = 8'h00; o = 1'b0; z = 1'b0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk); guard++;
    end
    if (!bus.in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", bus.in_ready);
      ok = 1'b0;
      return;
    end
    bus.in_valid = 1'b1; bus.dividend = a; bus.divisor = b;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.dividend = 16'($urandom); bus.divisor = 8'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk); lat++;
    end
    if (!bus.out_valid) begin
      n_checks++; n_fail++;
      $display("FAIL result_timeout: out_valid=%0b required 1", bus.out_valid);
      ok = 1'b0;
      return;
    end
    q = bus.quotient; r = bus.remainder; o = bus.ovf; z = bus.dbz;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== 8'h00 ||
        bus.remainder !== 8'h00 || bus.ovf !== 1'b0 || bus.dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%0b vld=%0b q=%h r=%h ovf=%0b dbz=%0b required 1 0 00 00 0 0",
               bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.ovf, bus.dbz);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: in_ready=%0b required 1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [7:0] q, r; logic o, z; int lat; bit ok;
    for (int i = 0; i < 7; i++) begin
      do_op(dir_a[i], dir_b[i], q, r, o, z, lat, ok);
      if (ok) begin
        n_checks++;
        if (q !== dir_q[i] || r !== dir_r[i] || o !== dir_o[i] || z !== dir_z[i]) begin
          n_fail++;
          $display("FAIL directed_%0d: got q=%h r=%h ovf=%0b dbz=%0b required q=%h r=%h ovf=%0b dbz=%0b",
                   i, q, r, o, z, dir_q[i], dir_r[i], dir_o[i], dir_z[i]);
        end
        n_checks++;
        if (lat !== 18) begin
          n_fail++;
          $display("FAIL latency_%0d: out_valid at cycle %0d required 18", i, lat);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0] eq, er; logic eo, ez; int guard;
    ref_div(16'hFB2E, 8'd37, eq, er, eo, ez);   // -1234 / 37
    bus.in_valid = 1'b1; bus.dividend = 16'hFB2E; bus.divisor = 8'd37;
    @(negedge clk);
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 100) begin
      @(negedge clk); guard++;
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quotient !== eq ||
          bus.remainder !== er || bus.ovf !== eo || bus.dbz !== ez) begin
        n_fail++;
        $display("FAIL hold_%0d: vld=%0b rdy=%0b q=%h r=%h ovf=%0b dbz=%0b required 1 0 %h %h %0b %0b",
                 k, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.ovf, bus.dbz,
                 eq, er, eo, ez);
      end
      bus.in_valid = k[0]; bus.dividend = 16'($urandom); bus.divisor = 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b1; bus.dividend = 16'd100; bus.divisor = 8'd7; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL retire: out_valid=%0b in_ready=%0b required 0 1", bus.out_valid, bus.in_ready);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL retire_no_accept: in_ready=%0b required 1", bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q, r; logic o, z; int lat; bit ok;
    bus.in_valid = 1'b1; bus.dividend = 16'd1000; bus.divisor = 8'd3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: out_valid=%0b in_ready=%0b required 0 1", bus.out_valid, bus.in_ready);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_no_result: out_valid=%0b required 0", bus.out_valid);
    end
    do_op(16'd100, 8'd7, q, r, o, z, lat, ok);
    if (ok) begin
      n_checks++;
      if (q !== 8'h0E || r !== 8'h02 || o !== 1'b0 || z !== 1'b0) begin
        n_fail++;
        $display("FAIL after_reset_op: q=%h r=%h ovf=%0b dbz=%0b required 0e 02 0 0", q, r, o, z);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] q, r, eq, er; logic o, z, eo, ez; int lat; bit ok;
    logic [15:0] a; logic [7:0] b; int sh, ai, bi, qs, rs;
    for (int n = 0; n < 2000; n++) begin
      sh = $urandom_range(0, 14);
      a = 16'($urandom);
      a = 16'($signed(a) >>> sh);
      case ($urandom_range(0, 9))
        0:       b = 8'h00;
        1:       b = 8'h80;
        2:       b = 8'hFF;
        default: b = 8'($urandom);
      endcase
      if (n == 0) a = 16'h8000;
      ref_div(a, b, eq, er, eo, ez);
      do_op(a, b, q, r, o, z, lat, ok);
      if (!ok) break;
      n_checks++;
      if (q !== eq || r !== er || o !== eo || z !== ez) begin
        n_fail++;
        $display("FAIL random %h/%h: got q=%h r=%h ovf=%0b dbz=%0b required q=%h r=%h ovf=%0b dbz=%0b",
                 a, b, q, r, o, z, eq, er, eo, ez);
      end
      if (!eo && !ez) begin
        ai = $signed(a); bi = $signed(b); qs = $signed(q); rs = $signed(r);
        n_checks++;
        if (ai != qs * bi + rs || (rs < 0 ? -rs : rs) >= (bi < 0 ? -bi : bi) ||
            (rs != 0 && ((rs < 0) != (ai < 0)))) begin
          n_fail++;
          $display("FAIL identity %0d/%0d: q=%0d r=%0d required q*d+r=dividend, |r|<|d|", ai, bi, qs, rs);
        end
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.dividend = 16'h0000; bus.divisor = 8'h00; bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
